// File: rtl/dmem_pkg.sv
// Shared encodings for the MEM-stage data memory: request op codes, write-source select, FSM states.
package dmem_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_LOAD  = 3'd1,
    OP_STORE = 3'd2,
    OP_PUSH  = 3'd3,
    OP_POP   = 3'd4
  } dmem_op_e;

  typedef enum logic {
    SRC_RF = 1'b0,
    SRC_PC = 1'b1
  } dmem_src_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } dmem_state_e;

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM: per-byte write enable, registered read that holds between reads.
module dmem_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 256,
  localparam int unsigned ADDR_W = $clog2(DEPTH),
  localparam int unsigned BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BE_W-1:0]   we,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < BE_W; i++) begin
      if (we[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
  end

  // Read register is reset; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[addr];
  end

endmodule

// File: rtl/stack_data_memory.sv
// MEM-stage data memory: load/store, full-descending hardware stack, post-reset clear FSM.
// Optional macro DMEM_BYTE_WRITE_EN adds the byte_en port for masked STORE/PUSH writes.
module stack_data_memory
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned DEPTH          = 256,
  parameter int unsigned STACK_BASE     = 224,
  parameter int unsigned STACK_LIMIT    = 192,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  localparam int unsigned ADDR_W = $clog2(DEPTH),
  localparam int unsigned BE_W   = DATA_W / 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [31:0]       alu_address,
  input  logic [DATA_W-1:0] reg_data,
  input  logic [DATA_W-1:0] pc_data,
  input  logic              wr_src,
`ifdef DMEM_BYTE_WRITE_EN
  input  logic [BE_W-1:0]   byte_en,
`endif
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] stack_ptr,
  output logic              stack_err,
  output logic              addr_err
);

  localparam logic [ADDR_W-1:0] SP_BASE  = ADDR_W'(STACK_BASE);
  localparam logic [ADDR_W-1:0] SP_LIMIT = ADDR_W'(STACK_LIMIT);
  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

  dmem_state_e       state_q, state_d;
  logic [ADDR_W-1:0] clear_cnt_q, clear_cnt_d;
  logic [ADDR_W-1:0] sp_q, sp_d;
  logic              clearing;

  logic              fire;
  logic              addr_ok;
  logic [DATA_W-1:0] wdata;
  logic [BE_W-1:0]   wr_mask;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [BE_W-1:0]   ram_we;
  logic              ram_rd_en;

  logic              rd_valid_d, stack_err_d, addr_err_d;

  // FSM state register
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      clear_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      clear_cnt_q <= clear_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clear_cnt_d = clear_cnt_q;
    clearing    = 1'b0;
    req_ready   = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clearing    = 1'b1;
        clear_cnt_d = clear_cnt_q + ADDR_W'(1);
        if (clear_cnt_q == CNT_LAST) state_d = ST_READY;
      end
      ST_READY: req_ready = 1'b1;
      default:  state_d = ST_READY;
    endcase
  end

  assign wdata   = (wr_src == SRC_PC) ? pc_data : reg_data;
  assign addr_ok = (alu_address < 32'(DEPTH));
  assign fire    = req_valid & req_ready;

`ifdef DMEM_BYTE_WRITE_EN
  assign wr_mask = byte_en;
`else
  assign wr_mask = '1;
`endif

  // Single RAM port shared by clear, load/store and stack traffic; the FSM guarantees one user per cycle.
  always_comb begin
    ram_addr    = alu_address[ADDR_W-1:0];
    ram_wdata   = wdata;
    ram_we      = '0;
    ram_rd_en   = 1'b0;
    sp_d        = sp_q;
    rd_valid_d  = 1'b0;
    stack_err_d = 1'b0;
    addr_err_d  = 1'b0;
    if (clearing) begin
      ram_addr  = clear_cnt_q;
      ram_wdata = '0;
      ram_we    = '1;
    end else if (fire) begin
      case (req_op)
        OP_LOAD: begin
          if (addr_ok) begin
            ram_rd_en  = 1'b1;
            rd_valid_d = 1'b1;
          end else begin
            addr_err_d = 1'b1;
          end
        end
        OP_STORE: begin
          if (addr_ok) ram_we = wr_mask;
          else         addr_err_d = 1'b1;
        end
        OP_PUSH: begin
          if (sp_q == SP_LIMIT) begin
            stack_err_d = 1'b1;
          end else begin
            sp_d     = sp_q - ADDR_W'(1);
            ram_addr = sp_q - ADDR_W'(1);
            ram_we   = wr_mask;
          end
        end
        OP_POP: begin
          if (sp_q == SP_BASE) begin
            stack_err_d = 1'b1;
          end else begin
            ram_addr   = sp_q;
            ram_rd_en  = 1'b1;
            rd_valid_d = 1'b1;
            sp_d       = sp_q + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
    // No memory writes on a reset edge, even mid-clear.
    if (!reset) ram_we = '0;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sp_q      <= SP_BASE;
      rd_valid  <= 1'b0;
      stack_err <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      sp_q      <= sp_d;
      rd_valid  <= rd_valid_d;
      stack_err <= stack_err_d;
      addr_err  <= addr_err_d;
    end
  end

  assign stack_ptr = sp_q;

  dmem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clock),
    .rst_n   (reset),
    .addr    (ram_addr),
    .wdata   (ram_wdata),
    .we      (ram_we),
    .rd_en   (ram_rd_en),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_stack_data_memory.sv
// Randomized self-checking bench for stack_data_memory against an array/integer reference model.
module tb_stack_data_memory;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] alu_address;
  logic [31:0] reg_data;
  logic [31:0] pc_data;
  logic        wr_src;
  logic [3:0]  byte_en;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [7:0]  stack_ptr;
  logic        stack_err;
  logic        addr_err;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] m_mem [256];
  int          m_sp;
  logic [31:0] m_rd;
  logic        m_rv, m_se, m_ae;

  always #5 clock = ~clock;

  stack_data_memory #(
    .DATA_W         (32),
    .DEPTH          (256),
    .STACK_BASE     (224),
    .STACK_LIMIT    (192),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .alu_address (alu_address),
    .reg_data    (reg_data),
    .pc_data     (pc_data),
    .wr_src      (wr_src),
`ifdef DMEM_BYTE_WRITE_EN
    .byte_en     (byte_en),
`endif
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .stack_ptr   (stack_ptr),
    .stack_err   (stack_err),
    .addr_err    (addr_err)
  );

  // Drives one request for a single cycle and advances the model; returns #1 after the firing edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] rdat,
                       input logic [31:0] pdat, input logic src, input logic [3:0] be, input bit valid);
    logic [31:0] w;
    logic [3:0]  bm;
    req_valid = valid; req_op = op; alu_address = addr;
    reg_data = rdat; pc_data = pdat; wr_src = src; byte_en = be;
    w = src ? pdat : rdat;
`ifdef DMEM_BYTE_WRITE_EN
    bm = be;
`else
    bm = 4'hF;
`endif
    m_rv = 1'b0; m_se = 1'b0; m_ae = 1'b0;
    if (valid) begin
      case (op)
        3'd1: if (addr >= 256) m_ae = 1'b1;
              else begin m_rd = m_mem[addr]; m_rv = 1'b1; end
        3'd2: if (addr >= 256) m_ae = 1'b1;
              else for (int i = 0; i < 4; i++) if (bm[i]) m_mem[addr][i*8 +: 8] = w[i*8 +: 8];
        3'd3: if (m_sp == 192) m_se = 1'b1;
              else begin
                m_sp = m_sp - 1;
                for (int i = 0; i < 4; i++) if (bm[i]) m_mem[m_sp][i*8 +: 8] = w[i*8 +: 8];
              end
        3'd4: if (m_sp == 224) m_se = 1'b1;
              else begin m_rd = m_mem[m_sp]; m_sp = m_sp + 1; m_rv = 1'b1; end
        default: ;
      endcase
    end
    @(posedge clock); #1;
    req_valid = 1'b0; req_op = 3'd0;
  endtask

  // Counts cycles with req_ready low, bounded so a stuck FSM still reaches the summary.
  task automatic wait_clear(output int n);
    n = 0;
    while (req_ready !== 1'b1 && n < 1000) begin
      n++;
      @(posedge clock); #1;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_mem[i] = '0;
    m_sp = 224; m_rd = '0; m_rv = 1'b0; m_se = 1'b0; m_ae = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b0; req_valid = 1'b0; req_op = 3'd0; alu_address = '0;
    reg_data = '0; pc_data = '0; wr_src = 1'b0; byte_en = 4'hF;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (rd_valid !== 1'b0)    begin errors++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
    checks++; if (stack_err !== 1'b0)   begin errors++; $display("FAIL reset_stack_err got %b exp 0", stack_err); end
    checks++; if (addr_err !== 1'b0)    begin errors++; $display("FAIL reset_addr_err got %b exp 0", addr_err); end
    checks++; if (stack_ptr !== 8'd224) begin errors++; $display("FAIL reset_sp got %0d exp 224", stack_ptr); end
    checks++; if (rd_data !== 32'h0)    begin errors++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
    checks++; if (req_ready !== 1'b0)   begin errors++; $display("FAIL reset_ready got %b exp 0", req_ready); end
    reset = 1'b1;
    wait_clear(n);
    checks++; if (n != 256) begin errors++; $display("FAIL clear_cycles got %0d exp 256", n); end
    model_reset();
    for (int k = 0; k < 3; k++) begin
      logic [31:0] a;
      a = (k == 0) ? 32'd1 : (k == 1) ? 32'd2 : 32'd255;
      issue(3'd1, a, '0, '0, 1'b0, 4'hF, 1'b1);
      checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL clear_load_valid addr %0d got %b exp 1", a, rd_valid); end
      checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL clear_load_data addr %0d got %h exp 0", a, rd_data); end
    end
    issue(3'd0, '0, '0, '0, 1'b0, 4'hF, 1'b0);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_pulse got %b exp 0", rd_valid); end
  endtask

  task automatic test_back_to_back();
    issue(3'd2, 32'd2, 32'd4, 32'hDEAD, 1'b0, 4'hF, 1'b1);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL store_no_valid got %b exp 0", rd_valid); end
    issue(3'd1, 32'd2, '0, '0, 1'b0, 4'hF, 1'b1);
    checks++; if (rd_data !== m_rd || rd_valid !== 1'b1)
      begin errors++; $display("FAIL store_load got %h/%b exp %h/1", rd_data, rd_valid, m_rd); end
  endtask

  task automatic test_stack();
    issue(3'd3, '0, 32'hFFFF, 32'd16, 1'b1, 4'hF, 1'b1);
    checks++; if (stack_ptr !== 8'd223) begin errors++; $display("FAIL push_sp got %0d exp 223", stack_ptr); end
    issue(3'd4, '0, '0, '0, 1'b0, 4'hF, 1'b1);
    checks++; if (rd_data !== 32'd16 || rd_valid !== 1'b1)
      begin errors++; $display("FAIL pop_data got %h/%b exp 00000010/1", rd_data, rd_valid); end
    checks++; if (stack_ptr !== 8'd224) begin errors++; $display("FAIL pop_sp got %0d exp 224", stack_ptr); end
    issue(3'd4, '0, '0, '0, 1'b0, 4'hF, 1'b1);
    checks++; if (stack_err !== 1'b1 || rd_valid !== 1'b0 || stack_ptr !== 8'd224)
      begin errors++; $display("FAIL underflow got err=%b v=%b sp=%0d exp 1 0 224", stack_err, rd_valid, stack_ptr); end
    for (int i = 0; i < 32; i++) issue(3'd3, '0, $urandom, '0, 1'b0, 4'hF, 1'b1);
    checks++; if (stack_ptr !== 8'd192 || stack_err !== 1'b0)
      begin errors++; $display("FAIL fill_sp got %0d err=%b exp 192 0", stack_ptr, stack_err); end
    issue(3'd3, '0, 32'h1234, '0, 1'b0, 4'hF, 1'b1);
    checks++; if (stack_err !== 1'b1 || stack_ptr !== 8'd192)
      begin errors++; $display("FAIL overflow got err=%b sp=%0d exp 1 192", stack_err, stack_ptr); end
    issue(3'd0, '0, '0, '0, 1'b0, 4'hF, 1'b0);
    checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL stack_err_pulse got %b exp 0", stack_err); end
    issue(3'd1, 32'd191, '0, '0, 1'b0, 4'hF, 1'b1);
    checks++; if (rd_data !== m_rd) begin errors++; $display("FAIL overflow_nowrite got %h exp %h", rd_data, m_rd); end
  endtask

  task automatic test_addr_err();
    logic [31:0] hold;
    issue(3'd2, 32'd0, 32'h5A5A_0001, '0, 1'b0, 4'hF, 1'b1);
    hold = rd_data;
    issue(3'd1, 32'd256, '0, '0, 1'b0, 4'hF, 1'b1);
    checks++; if (addr_err !== 1'b1 || rd_valid !== 1'b0 || rd_data !== hold)
      begin errors++; $display("FAIL load_oob got err=%b v=%b d=%h exp 1 0 %h", addr_err, rd_valid, rd_data, hold); end
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, '0, 1'b0, 4'hF, 1'b1);
    checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL store_oob got %b exp 1", addr_err); end
    issue(3'd1, 32'd0, '0, '0, 1'b0, 4'hF, 1'b1);
    checks++; if (rd_data !== 32'h5A5A_0001 || addr_err !== 1'b0)
      begin errors++; $display("FAIL oob_nowrite got %h err=%b exp 5a5a0001 0", rd_data, addr_err); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      logic [2:0]  op;
      logic [31:0] a;
      int          r;
      r = $urandom_range(0, 99);
      // Phase-dependent bias drives the stack into both bounds.
      if (n < 200)      op = (r < 50) ? 3'd3 : 3'($urandom_range(0, 7));
      else if (n < 400) op = (r < 50) ? 3'd4 : 3'($urandom_range(0, 7));
      else              op = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? 32'd256 + $urandom_range(0, 1000) : 32'h8000_0000 | $urandom)
                                      : 32'($urandom_range(0, 255));
      issue(op, a, $urandom, $urandom, 1'($urandom_range(0, 1)), 4'($urandom), $urandom_range(0, 3) != 0);
      checks++; if (rd_valid !== m_rv)   begin errors++; $display("FAIL rnd_rd_valid step %0d got %b exp %b", n, rd_valid, m_rv); end
      checks++; if (rd_data !== m_rd)    begin errors++; $display("FAIL rnd_rd_data step %0d got %h exp %h", n, rd_data, m_rd); end
      checks++; if (stack_err !== m_se)  begin errors++; $display("FAIL rnd_stack_err step %0d got %b exp %b", n, stack_err, m_se); end
      checks++; if (addr_err !== m_ae)   begin errors++; $display("FAIL rnd_addr_err step %0d got %b exp %b", n, addr_err, m_ae); end
      checks++; if (stack_ptr !== 8'(m_sp)) begin errors++; $display("FAIL rnd_sp step %0d got %0d exp %0d", n, stack_ptr, m_sp); end
    end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    issue(3'd3, '0, 32'hCAFE_F00D, '0, 1'b0, 4'hF, 1'b1);
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (100) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock); #1;
    checks++; if (stack_ptr !== 8'd224 || req_ready !== 1'b0 || rd_data !== 32'h0)
      begin errors++; $display("FAIL midclear_reset got sp=%0d rdy=%b d=%h exp 224 0 0", stack_ptr, req_ready, rd_data); end
    reset = 1'b1;
    wait_clear(n);
    checks++; if (n != 256) begin errors++; $display("FAIL midclear_cycles got %0d exp 256", n); end
    model_reset();
    issue(3'd1, 32'd255, '0, '0, 1'b0, 4'hF, 1'b1);
    checks++; if (rd_data !== 32'h0 || rd_valid !== 1'b1)
      begin errors++; $display("FAIL midclear_load255 got %h/%b exp 0/1", rd_data, rd_valid); end
`ifdef DMEM_BYTE_WRITE_EN
    issue(3'd2, 32'd0, 32'hAABB_CCDD, '0, 1'b0, 4'b0101, 1'b1);
    issue(3'd1, 32'd0, '0, '0, 1'b0, 4'hF, 1'b1);
    checks++; if (rd_data !== 32'h00BB_00DD)
      begin errors++; $display("FAIL byte_write got %h exp 00bb00dd", rd_data); end
    issue(3'd3, '0, 32'h1111_1111, '0, 1'b0, 4'b0000, 1'b1);
    checks++; if (stack_ptr !== 8'd223) begin errors++; $display("FAIL be0_push_sp got %0d exp 223", stack_ptr); end
    issue(3'd4, '0, '0, '0, 1'b0, 4'hF, 1'b1);
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL be0_push_data got %h exp 0", rd_data); end
`endif
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stack();
    test_addr_err();
    test_random();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
